// File: rtl/fb_draw_sched.sv
// Framebuffer write-port owner and per-frame sequencer. It waits FRAME_WAIT
// frames after enable, clears the buffer to BG_CIDX, then starts and paces
// the renderer. It forwards renderer writes until LAT_DRAIN cycles after
// render_done. Every output is registered.
module fb_draw_sched #(
  parameter int unsigned CIDXW      = 4,
  parameter int unsigned FB_PIXELS  = 57600,
  parameter int unsigned FB_ADDRW   = 16,
  parameter int unsigned FRAME_WAIT = 120,
  parameter int unsigned BG_CIDX    = 0,
  parameter int unsigned LAT_DRAIN  = 3,
  parameter int unsigned PACED      = 1,
  parameter int unsigned LOOP       = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                frame,
  output logic                render_start,
  output logic                render_oe,
  input  logic                render_done,
  input  logic                drw_we,
  input  logic [FB_ADDRW-1:0] drw_addr,
  input  logic [CIDXW-1:0]    drw_cidx,
  output logic                fb_we,
  output logic [FB_ADDRW-1:0] fb_addr,
  output logic [CIDXW-1:0]    fb_cidx,
  output logic                busy,
  output logic [7:0]          pass_cnt
);

  localparam int unsigned WAITW = $clog2(FRAME_WAIT + 1);
  localparam int unsigned DRNW  = (LAT_DRAIN < 2) ? 1 : $clog2(LAT_DRAIN);

  localparam logic [WAITW-1:0]    WAIT_LAST = WAITW'(FRAME_WAIT - 1);
  // Terminal clear address is the last real pixel, not the top of the address space.
  localparam logic [FB_ADDRW-1:0] CLR_LAST  = FB_ADDRW'(FB_PIXELS - 1);
  localparam logic [DRNW-1:0]     DRN_LAST  = DRNW'(LAT_DRAIN - 1);
  localparam logic [CIDXW-1:0]    BG        = CIDXW'(BG_CIDX);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StArm,
    StDraw,
    StDrain,
    StDone
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [WAITW-1:0]    r_wait_cnt, w_wait_nxt;
  logic [FB_ADDRW-1:0] r_clr_addr, w_clr_nxt;
  logic [DRNW-1:0]     r_drn_cnt, w_drn_nxt;
  logic [7:0]          r_pass_cnt, w_pass_nxt;
  logic                r_render_start, w_start_nxt;
  logic                r_render_oe, w_oe_nxt;
  logic                r_fb_we, w_we_nxt;
  logic [FB_ADDRW-1:0] r_fb_addr, w_addr_nxt;
  logic [CIDXW-1:0]    r_fb_cidx, w_cidx_nxt;
  logic                r_busy, w_busy_nxt;

  // Next-state, counter and registered-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_clr_nxt   = r_clr_addr;
    w_drn_nxt   = r_drn_cnt;
    w_pass_nxt  = r_pass_cnt;
    w_start_nxt = 1'b0;
    w_oe_nxt    = 1'b0;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = '0;
    w_cidx_nxt  = '0;

    case (r_state)
      StIdle: begin
        if (!en) begin
          w_wait_nxt = '0;
        end else if (frame) begin
          if (r_wait_cnt == WAIT_LAST) begin
            w_state_nxt = StClear;
            w_clr_nxt   = '0;
            w_wait_nxt  = '0;
          end else begin
            w_wait_nxt = r_wait_cnt + 1'b1;
          end
        end
      end

      StClear: begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = r_clr_addr;
        w_cidx_nxt = BG;
        if (r_clr_addr == CLR_LAST) begin
          w_state_nxt = StArm;
          w_clr_nxt   = '0;
        end else begin
          w_clr_nxt = r_clr_addr + 1'b1;
        end
      end

      StArm: begin
        if (frame) begin
          w_start_nxt = 1'b1;
          // Paced: first oe pulse shares the start frame; unpaced: oe rises here and holds.
          w_oe_nxt    = 1'b1;
          w_state_nxt = StDraw;
        end
      end

      StDraw: begin
        w_we_nxt   = drw_we;
        w_addr_nxt = drw_addr;
        w_cidx_nxt = drw_cidx;
        if (render_done) begin
          // render_done beats a coincident frame: no further oe pulse.
          w_state_nxt = StDrain;
          w_drn_nxt   = '0;
        end else begin
          w_oe_nxt = (PACED != 0) ? frame : 1'b1;
        end
      end

      StDrain: begin
        w_we_nxt   = drw_we;
        w_addr_nxt = drw_addr;
        w_cidx_nxt = drw_cidx;
        if (r_drn_cnt == DRN_LAST) begin
          w_state_nxt = StDone;
          w_drn_nxt   = '0;
          w_pass_nxt  = r_pass_cnt + 1'b1;
        end else begin
          w_drn_nxt = r_drn_cnt + 1'b1;
        end
      end

      StDone: begin
        if (!en) begin
          w_state_nxt = StIdle;
          w_wait_nxt  = '0;
        end else if ((LOOP != 0) && frame) begin
          w_state_nxt = StClear;
          w_clr_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    w_busy_nxt = (w_state_nxt == StClear) || (w_state_nxt == StArm) ||
                 (w_state_nxt == StDraw) || (w_state_nxt == StDrain);
  end

  // State, counters and output registers; reset drops the write port at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_wait_cnt     <= '0;
      r_clr_addr     <= '0;
      r_drn_cnt      <= '0;
      r_pass_cnt     <= '0;
      r_render_start <= 1'b0;
      r_render_oe    <= 1'b0;
      r_fb_we        <= 1'b0;
      r_fb_addr      <= '0;
      r_fb_cidx      <= '0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_wait_cnt     <= w_wait_nxt;
      r_clr_addr     <= w_clr_nxt;
      r_drn_cnt      <= w_drn_nxt;
      r_pass_cnt     <= w_pass_nxt;
      r_render_start <= w_start_nxt;
      r_render_oe    <= w_oe_nxt;
      r_fb_we        <= w_we_nxt;
      r_fb_addr      <= w_addr_nxt;
      r_fb_cidx      <= w_cidx_nxt;
      r_busy         <= w_busy_nxt;
    end
  end

  assign render_start = r_render_start;
  assign render_oe    = r_render_oe;
  assign fb_we        = r_fb_we;
  assign fb_addr      = r_fb_addr;
  assign fb_cidx      = r_fb_cidx;
  assign busy         = r_busy;
  assign pass_cnt     = r_pass_cnt;

endmodule
